common_dffram_mwbnr: RTL and testbench

- Parametrised flip-flop RAM with bit write enables, WR_PORTS write ports and RD_PORTS asynchronous read ports.
- Adds deterministic write-port priority on conflicts and a sequenced bulk-clear engine with a busy/done handshake.
- Used for register files, rename tables and predictor tables in the core, where reads must resolve in the same cycle and tables need a flush without a global reset.

---
 rtl/common_dffram_mwbnr.sv | 116 +++++++++++
 tb/tb_common_dffram_mwbnr.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/common_dffram_mwbnr.sv
// rtl/common_dffram_mwbnr.sv - multi-write, multi-read flop RAM with per-bit enables and bulk clear
// Optional macro COMMON_DFFRAM_MWBNR_BYPASS_EN merges this cycle's accepted writes into reads.
module common_dffram_mwbnr #(
  parameter int                        RAM_DATA_WIDTH  = 8,
  parameter int                        RAM_ADDR_WIDTH  = 4,
  parameter int                        WR_PORTS        = 2,
  parameter int                        RD_PORTS        = 2,
  parameter logic [RAM_DATA_WIDTH-1:0] RAM_RESET_VALUE = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [WR_PORTS-1:0]                wr_en,
  input  logic [WR_PORTS*RAM_ADDR_WIDTH-1:0] wr_addr,
  input  logic [WR_PORTS*RAM_DATA_WIDTH-1:0] wr_be,
  input  logic [WR_PORTS*RAM_DATA_WIDTH-1:0] wr_data,
  output logic                               wr_ready,
  input  logic [RD_PORTS*RAM_ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_PORTS*RAM_DATA_WIDTH-1:0] rd_data,
  input  logic                               clr_req,
  output logic                               clr_busy,
  output logic                               clr_done
);

  localparam int DW    = RAM_DATA_WIDTH;
  localparam int AW    = RAM_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         mem_q [DEPTH];
  logic [DW-1:0]         mem_d [DEPTH];
  logic [WR_PORTS-1:0]   wr_acc;

  // Ports are applied in ascending order so the highest-numbered writer owns each contested bit.
  function automatic logic [DW-1:0] merge_writes(
    input logic [DW-1:0]          base,
    input logic [AW-1:0]          addr,
    input logic [WR_PORTS-1:0]    en,
    input logic [WR_PORTS*AW-1:0] wa,
    input logic [WR_PORTS*DW-1:0] be,
    input logic [WR_PORTS*DW-1:0] wd
  );
    logic [DW-1:0] v;
    v = base;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (en[p] && (wa[p*AW +: AW] == addr)) begin
        v = (v & ~be[p*DW +: DW]) | (wd[p*DW +: DW] & be[p*DW +: DW]);
      end
    end
    return v;
  endfunction

  assign clr_busy = (state_q == CLEAR);
  assign clr_done = (state_q == DONE);
  assign wr_ready = ~clr_busy;
  assign wr_acc   = wr_en & {WR_PORTS{wr_ready}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      mem_d[a] = merge_writes(mem_q[a], AW'(a), wr_acc, wr_addr, wr_be, wr_data);
      if (clr_busy && (cnt_q == AW'(a))) begin
        mem_d[a] = RAM_RESET_VALUE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= RAM_RESET_VALUE;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= mem_d[a];
      end
    end
  end

  for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
`ifdef COMMON_DFFRAM_MWBNR_BYPASS_EN
    assign rd_data[r*DW +: DW] = merge_writes(mem_q[rd_addr[r*AW +: AW]], rd_addr[r*AW +: AW],
                                              wr_acc, wr_addr, wr_be, wr_data);
`else
    assign rd_data[r*DW +: DW] = mem_q[rd_addr[r*AW +: AW]];
`endif
  end

endmodule

// File: tb/tb_common_dffram_mwbnr.sv
// tb/tb_common_dffram_mwbnr.sv - scoreboard bench for common_dffram_mwbnr
module tb_common_dffram_mwbnr;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_be;
  logic [15:0] wr_data;
  logic [7:0]  rd_addr;
  logic        clr_req;
  logic        wr_ready, clr_busy, clr_done;
  logic [15:0] rd_data;
  logic        wr_ready2, clr_busy2, clr_done2;
  logic [15:0] rd_data2;

  int checks = 0;
  int errors = 0;

  int         q_sel [$];
  logic [7:0] q_val [$];
  string      q_nm  [$];

  always #5 clk = ~clk;

  common_dffram_mwbnr dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  common_dffram_mwbnr #(.RAM_RESET_VALUE(8'hC3)) dut_c3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .wr_ready(wr_ready2), .rd_addr(rd_addr), .rd_data(rd_data2),
    .clr_req(clr_req), .clr_busy(clr_busy2), .clr_done(clr_done2)
  );

  // Monitor: everything queued during the high phase is compared at the falling edge.
  int         m_sel;
  logic [7:0] m_exp, m_act;
  string      m_nm;
  always @(negedge clk) begin
    while (q_sel.size() > 0) begin
      m_sel = q_sel.pop_front();
      m_exp = q_val.pop_front();
      m_nm  = q_nm.pop_front();
      case (m_sel)
        0:       m_act = rd_data[7:0];
        1:       m_act = rd_data[15:8];
        2:       m_act = {5'b0, clr_busy, clr_done, wr_ready};
        3:       m_act = rd_data2[7:0];
        4:       m_act = rd_data2[15:8];
        default: m_act = {5'b0, clr_busy2, clr_done2, wr_ready2};
      endcase
      checks++;
      if (m_act !== m_exp) begin
        errors++;
        $display("FAIL %s actual=%h expected=%h", m_nm, m_act, m_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int sel, input logic [7:0] v, input string nm);
    q_sel.push_back(sel);
    q_val.push_back(v);
    q_nm.push_back(nm);
  endtask

  task automatic fill_5a();
    for (int a = 0; a < 16; a++) begin
      wr_en   = 2'b01;
      wr_addr = {4'd0, a[3:0]};
      wr_be   = 16'h00FF;
      wr_data = 16'h005A;
      tick();
    end
    wr_en = 2'b00;
  endtask

  initial begin
    reset = 1'b0; wr_en = '0; wr_addr = '0; wr_be = '0; wr_data = '0; rd_addr = '0; clr_req = 1'b0;
    tick();
    for (int a = 0; a < 16; a++) begin
      rd_addr = {a[3:0], a[3:0]};
      expect_val(0, 8'h00, "rst_rd0");
      expect_val(1, 8'h00, "rst_rd1");
      expect_val(3, 8'hC3, "rst_c3_rd0");
      expect_val(4, 8'hC3, "rst_c3_rd1");
      tick();
    end
    expect_val(2, 8'h01, "rst_status");
    expect_val(5, 8'h01, "rst_status_c3");
    tick();
    reset = 1'b1;
    tick();

    // single write and its latency
    wr_en = 2'b01; wr_addr = {4'd0, 4'd3}; wr_be = 16'h00FF; wr_data = 16'h00A5; rd_addr = {4'd0, 4'd3};
`ifdef COMMON_DFFRAM_MWBNR_BYPASS_EN
    expect_val(0, 8'hA5, "bypass_a5");
`else
    expect_val(0, 8'h00, "pre_write_a5");
`endif
    tick();
    wr_en = 2'b00;
    expect_val(0, 8'hA5, "write_a5");
    tick();

    // per-bit conflict: port1 owns the low nibble
    wr_en = 2'b11; wr_addr = {4'd5, 4'd5}; wr_be = 16'h0FFF; wr_data = 16'hEE11; rd_addr = {4'd5, 4'd3};
`ifdef COMMON_DFFRAM_MWBNR_BYPASS_EN
    expect_val(1, 8'h1E, "bypass_conflict");
`else
    expect_val(1, 8'h00, "pre_conflict");
`endif
    tick();
    wr_en = 2'b00;
    expect_val(1, 8'h1E, "conflict_1e");
    expect_val(0, 8'hA5, "hold_e3");
    tick();

    // partial byte enables hold untouched bits
    wr_en = 2'b01; wr_addr = {4'd0, 4'd5}; wr_be = 16'h00F0; wr_data = 16'h009C;
    tick();
    wr_en = 2'b00;
    expect_val(1, 8'h9E, "partial_be");
    tick();

    // two ports, two addresses
    wr_en = 2'b11; wr_addr = {4'd7, 4'd6}; wr_be = 16'hFFFF; wr_data = 16'h7766;
    tick();
    wr_en = 2'b00; rd_addr = {4'd7, 4'd6};
    expect_val(0, 8'h66, "dual_e6");
    expect_val(1, 8'h77, "dual_e7");
    tick();

    // bulk clear with dropped writes
    fill_5a();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      expect_val(2, 8'h04, "clr_busy");
      wr_en = 2'b00;
      if (k == 1) begin
        wr_en = 2'b01; wr_addr = {4'd0, 4'd15}; wr_be = 16'h00FF; wr_data = 16'h0077;
      end
      if (k == 5) begin
        rd_addr = {4'd4, 4'd3};
        expect_val(0, 8'h00, "clr_e3_cleared");
        expect_val(1, 8'h5A, "clr_e4_old");
        wr_en = 2'b10; wr_addr = {4'd0, 4'd0}; wr_be = 16'hFF00; wr_data = 16'h7700;
      end
      tick();
    end
    wr_en = 2'b00;
    expect_val(2, 8'h03, "clr_done");
    tick();
    expect_val(2, 8'h01, "clr_idle");
    tick();
    for (int a = 0; a < 16; a++) begin
      rd_addr = {a[3:0], a[3:0]};
      expect_val(0, 8'h00, "after_clr_rd0");
      expect_val(1, 8'h00, "after_clr_rd1");
      expect_val(3, 8'hC3, "after_clr_c3");
      tick();
    end

    // clr_req held high restarts after one IDLE cycle
    fill_5a();
    clr_req = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      expect_val(2, 8'h04, "hold_busy");
      tick();
    end
    expect_val(2, 8'h03, "hold_done");
    tick();
    expect_val(2, 8'h01, "hold_idle");
    tick();
    expect_val(2, 8'h04, "hold_restart");
    clr_req = 1'b0;
    begin
      int n;
      n = 0;
      while (!clr_done && n < 40) begin
        tick();
        n++;
      end
      checks++;
      if (!clr_done) begin
        errors++;
        $display("FAIL restart_done_timeout actual=%0d expected<40", n);
      end
    end
    tick();

    // reset mid-clear
    fill_5a();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    rd_addr = {4'd6, 4'd5};
    expect_val(0, 8'h00, "mid_e5_cleared");
    expect_val(1, 8'h5A, "mid_e6_old");
    expect_val(3, 8'hC3, "mid_c3_e5_cleared");
    expect_val(4, 8'h5A, "mid_c3_e6_old");
    tick();
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd_addr = {a[3:0], a[3:0]};
      expect_val(0, 8'h00, "abort_rd0");
      expect_val(3, 8'hC3, "abort_c3_rd0");
      expect_val(2, 8'h01, "abort_status");
      expect_val(5, 8'h01, "abort_status_c3");
      tick();
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_val(2, 8'h01, "no_done_after_abort");
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
